// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bundle: stall, imem handshake, direction-predictor port, EX redirect/BTB update and IF/ID outputs.
// master = fetch unit, slave = surrounding pipeline/memory/predictor.
interface fetch_pc_unit_if;
  logic        stall;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] bp_raddr;
  logic        bp_take;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_uncond;
  logic        instr_valid;
  logic [31:0] instr_o;
  logic [31:0] instr_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  modport master (
    input  stall, imem_resp, imem_rdata, bp_take, redirect, redirect_pc,
           upd_valid, upd_pc, upd_target, upd_uncond,
    output imem_read, imem_addr, bp_raddr, instr_valid, instr_o, instr_pc,
           pred_taken, pred_target
  );

  modport slave (
    output stall, imem_resp, imem_rdata, bp_take, redirect, redirect_pc,
           upd_valid, upd_pc, upd_target, upd_uncond,
    input  imem_read, imem_addr, bp_raddr, instr_valid, instr_o, instr_pc,
           pred_taken, pred_target
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// RV32I fetch front end: PC register, imem read handshake and a direct-mapped BTB
// whose hit is qualified by the downstream direction predictor's bp_take.
//
// state | meaning
// FETCH | read of pc_q outstanding, waiting for imem_resp
// HOLD  | instruction delivered but IF/ID stalled; outputs replayed from hold regs
// DROP  | redirected while a read was outstanding; discard its response, then go to pend
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter int          BTB_IDX   = 6,
  parameter int          PC_OFFSET = 2
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_unit_if.master bus
);

  localparam int TAG_LSB = BTB_IDX + PC_OFFSET;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int N_ENT   = 1 << BTB_IDX;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic [31:0] r_pend, w_pend_n;
  logic [31:0] r_hold_instr, r_hold_pc, r_hold_npc;
  logic        r_hold_pred;
  logic        w_hold_load;
  logic        w_read, w_valid, w_use_hold;

  logic [N_ENT-1:0] r_btb_valid;
  logic [N_ENT-1:0] r_btb_unc;
  logic [TAG_W-1:0] r_btb_tag [N_ENT];
  logic [31:0]      r_btb_tgt [N_ENT];

  logic [BTB_IDX-1:0] w_idx, w_upd_idx;
  logic               w_hit, w_pred;
  logic [31:0]        w_npc;
  logic               w_unused;

  assign w_idx     = r_pc[TAG_LSB-1:PC_OFFSET];
  assign w_upd_idx = bus.upd_pc[TAG_LSB-1:PC_OFFSET];
  assign w_unused  = ^bus.upd_pc[PC_OFFSET-1:0];

  // Lookup reads registered entries only, so a same-cycle write is seen next cycle.
  assign w_hit  = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == r_pc[31:TAG_LSB]);
  assign w_pred = w_hit && (r_btb_unc[w_idx] || bus.bp_take);
  assign w_npc  = w_pred ? r_btb_tgt[w_idx] : r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_pend       <= '0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_hold_npc   <= '0;
      r_hold_pred  <= 1'b0;
      r_btb_valid  <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_pend  <= w_pend_n;
      if (w_hold_load) begin
        r_hold_instr <= bus.imem_rdata;
        r_hold_pc    <= r_pc;
        r_hold_npc   <= w_npc;
        r_hold_pred  <= w_pred;
      end
      if (bus.upd_valid) r_btb_valid[w_upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.upd_valid) begin
      r_btb_tag[w_upd_idx] <= bus.upd_pc[31:TAG_LSB];
      r_btb_tgt[w_upd_idx] <= bus.upd_target;
      r_btb_unc[w_upd_idx] <= bus.upd_uncond;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_pend_n    = r_pend;
    w_hold_load = 1'b0;
    w_read      = 1'b0;
    w_valid     = 1'b0;
    w_use_hold  = 1'b0;
    case (r_state)
      FETCH: begin
        w_read = 1'b1;
        if (bus.redirect) begin
          if (bus.imem_resp) begin
            w_pc_n = bus.redirect_pc;
          end else begin
            w_pend_n  = bus.redirect_pc;
            w_state_n = DROP;
          end
        end else if (bus.imem_resp) begin
          w_valid = 1'b1;
          if (bus.stall) begin
            w_hold_load = 1'b1;
            w_state_n   = HOLD;
          end else begin
            w_pc_n = w_npc;
          end
        end
      end
      HOLD: begin
        w_use_hold = 1'b1;
        if (bus.redirect) begin
          w_pc_n    = bus.redirect_pc;
          w_state_n = FETCH;
        end else begin
          w_valid = 1'b1;
          if (!bus.stall) begin
            w_pc_n    = r_hold_npc;
            w_state_n = FETCH;
          end
        end
      end
      DROP: begin
        w_read = 1'b1;
        if (bus.redirect) w_pend_n = bus.redirect_pc;
        if (bus.imem_resp) begin
          w_pc_n    = bus.redirect ? bus.redirect_pc : r_pend;
          w_state_n = FETCH;
        end
      end
      default: w_state_n = FETCH;
    endcase
  end

  assign bus.imem_read   = w_read;
  assign bus.imem_addr   = r_pc;
  assign bus.bp_raddr    = r_pc;
  assign bus.instr_valid = w_valid && !rst;
  assign bus.instr_o     = w_use_hold ? r_hold_instr : bus.imem_rdata;
  assign bus.instr_pc    = w_use_hold ? r_hold_pc    : r_pc;
  assign bus.pred_taken  = w_use_hold ? r_hold_pred  : w_pred;
  assign bus.pred_target = w_use_hold ? r_hold_npc   : w_npc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit: one vector per clock cycle,
// followed by hand-written reset-mid-DROP sequence.
module tb_fetch_pc_unit;

  logic clk;
  logic rst;
  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (.clk(clk), .rst(rst), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, resp;
    logic [31:0] rdata;
    logic        take, redir;
    logic [31:0] rpc;
    logic        upd;
    logic [31:0] upc, utgt;
    logic        unc;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_ipc;
    logic        e_pred;
    logic [31:0] e_tgt;
  } vec_t;

  localparam logic [31:0] J = 32'hBAD0_BAD0;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  function automatic vec_t V(
    input logic stall, resp, input logic [31:0] rdata, input logic take, redir,
    input logic [31:0] rpc, input logic upd, input logic [31:0] upc, utgt, input logic unc,
    input logic e_read, input logic [31:0] e_addr, input logic e_valid,
    input logic [31:0] e_instr, e_ipc, input logic e_pred, input logic [31:0] e_tgt);
    vec_t v;
    v.stall = stall; v.resp = resp; v.rdata = rdata; v.take = take; v.redir = redir;
    v.rpc = rpc; v.upd = upd; v.upc = upc; v.utgt = utgt; v.unc = unc;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_ipc = e_ipc; v.e_pred = e_pred; v.e_tgt = e_tgt;
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, check at the falling edge, then let the edge happen.
  task automatic apply(input vec_t v, input logic r, input string name);
    logic ok;
    @(posedge clk);
    #1;
    rst             = r;
    bus.stall       = v.stall;
    bus.imem_resp   = v.resp;
    bus.imem_rdata  = v.rdata;
    bus.bp_take     = v.take;
    bus.redirect    = v.redir;
    bus.redirect_pc = v.rpc;
    bus.upd_valid   = v.upd;
    bus.upd_pc      = v.upc;
    bus.upd_target  = v.utgt;
    bus.upd_uncond  = v.unc;
    @(negedge clk);
    ok = (bus.imem_read === v.e_read) && (bus.imem_addr === v.e_addr) &&
         (bus.bp_raddr === v.e_addr) && (bus.instr_valid === v.e_valid);
    if (v.e_valid)
      ok = ok && (bus.instr_o === v.e_instr) && (bus.instr_pc === v.e_ipc) &&
           (bus.pred_taken === v.e_pred) && (bus.pred_target === v.e_tgt);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got read=%0b addr=%h bpaddr=%h valid=%0b instr=%h pc=%h pred=%0b tgt=%h; want read=%0b addr=%h valid=%0b instr=%h pc=%h pred=%0b tgt=%h",
               name, bus.imem_read, bus.imem_addr, bus.bp_raddr, bus.instr_valid, bus.instr_o,
               bus.instr_pc, bus.pred_taken, bus.pred_target, v.e_read, v.e_addr, v.e_valid,
               v.e_instr, v.e_ipc, v.e_pred, v.e_tgt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.imem_resp = 0; bus.imem_rdata = J; bus.bp_take = 0;
    bus.redirect = 0; bus.redirect_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0;
    bus.upd_target = 0; bus.upd_uncond = 0;

    //         stl rsp rdata         tk rd rpc           up upc    utgt     un | rd addr          v instr         ipc           pr tgt
    tbl.push_back(V(0,1,32'hC000_0060,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h60,       1,32'hC000_0060,32'h60,       0,32'h64));
    tbl.push_back(V(0,1,32'hC000_0064,0,0,32'h0,        1,32'h64,32'h200, 1,  1,32'h64,       1,32'hC000_0064,32'h64,       0,32'h68));
    tbl.push_back(V(0,1,32'hC000_0068,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h68,       1,32'hC000_0068,32'h68,       0,32'h6C));
    tbl.push_back(V(0,1,J,            0,1,32'h64,       0,32'h0, 32'h0,   0,  1,32'h6C,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,32'hC000_0064,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h64,       1,32'hC000_0064,32'h64,       1,32'h200));
    tbl.push_back(V(0,0,J,            0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h200,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,J,            0,1,32'h64,       1,32'h64,32'h200, 0,  1,32'h200,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,32'hC000_0064,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h64,       1,32'hC000_0064,32'h64,       0,32'h68));
    tbl.push_back(V(0,1,J,            0,1,32'h64,       0,32'h0, 32'h0,   0,  1,32'h68,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,32'hC000_0064,1,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h64,       1,32'hC000_0064,32'h64,       1,32'h200));
    tbl.push_back(V(0,1,J,            0,1,32'h70,       0,32'h0, 32'h0,   0,  1,32'h200,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(1,1,32'hC000_0070,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h70,       1,32'hC000_0070,32'h70,       0,32'h74));
    tbl.push_back(V(1,0,J,            1,0,32'h0,        0,32'h0, 32'h0,   0,  0,32'h70,       1,32'hC000_0070,32'h70,       0,32'h74));
    tbl.push_back(V(1,0,J,            0,0,32'h0,        0,32'h0, 32'h0,   0,  0,32'h70,       1,32'hC000_0070,32'h70,       0,32'h74));
    tbl.push_back(V(0,0,J,            1,0,32'h0,        0,32'h0, 32'h0,   0,  0,32'h70,       1,32'hC000_0070,32'h70,       0,32'h74));
    tbl.push_back(V(0,0,J,            0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h74,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,J,            0,1,32'h80,       0,32'h0, 32'h0,   0,  1,32'h74,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,0,J,            0,1,32'h400,      0,32'h0, 32'h0,   0,  1,32'h80,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,0,J,            0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h80,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,0,J,            0,1,32'h500,      0,32'h0, 32'h0,   0,  1,32'h80,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,J,            0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h80,       0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,32'hC000_0500,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h500,      1,32'hC000_0500,32'h500,      0,32'h504));
    tbl.push_back(V(0,0,J,            0,1,32'h400,      0,32'h0, 32'h0,   0,  1,32'h504,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,J,            0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h504,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(1,1,32'hC000_0400,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h400,      1,32'hC000_0400,32'h400,      0,32'h404));
    tbl.push_back(V(1,0,J,            0,1,32'h600,      0,32'h0, 32'h0,   0,  0,32'h400,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,32'hC000_0600,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h600,      1,32'hC000_0600,32'h600,      0,32'h604));
    tbl.push_back(V(0,0,J,            0,1,32'h700,      0,32'h0, 32'h0,   0,  1,32'h604,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,J,            0,1,32'h800,      0,32'h0, 32'h0,   0,  1,32'h604,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,32'hC000_0800,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h800,      1,32'hC000_0800,32'h800,      0,32'h804));
    tbl.push_back(V(0,1,J,            0,1,32'hFFFF_FFFC,0,32'h0, 32'h0,   0,  1,32'h804,      0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(V(0,1,32'hC000_0FFC,0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'hFFFF_FFFC,1,32'hC000_0FFC,32'hFFFF_FFFC,0,32'h0));
    tbl.push_back(V(0,0,J,            0,0,32'h0,        0,32'h0, 32'h0,   0,  1,32'h0,        0,32'h0,        32'h0,        0,32'h0));

    // Reset with a response present: nothing may be delivered.
    @(posedge clk);
    apply(V(0,1,J,0,0,32'h0,0,32'h0,32'h0,0, 1,32'h60,0,32'h0,32'h0,0,32'h0), 1'b1, "reset_cycle");
    apply(V(0,0,J,0,0,32'h0,0,32'h0,32'h0,0, 1,32'h60,0,32'h0,32'h0,0,32'h0), 1'b0, "post_reset");

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Enter DROP toward 0x64, reset mid-DROP, then a late response belongs to RESET_PC
    // and the previously trained 0x64 entry must be gone.
    apply(V(0,0,J,0,1,32'h64,0,32'h0,32'h0,0, 1,32'h0,0,32'h0,32'h0,0,32'h0), 1'b0, "enter_drop");
    apply(V(0,1,J,0,0,32'h0,0,32'h0,32'h0,0, 1,32'h0,0,32'h0,32'h0,0,32'h0), 1'b1, "rst_mid_drop");
    apply(V(0,1,32'hC000_0060,1,0,32'h0,0,32'h0,32'h0,0, 1,32'h60,1,32'hC000_0060,32'h60,0,32'h64), 1'b0, "late_resp_reset_pc");
    apply(V(0,1,32'hC000_0064,1,0,32'h0,0,32'h0,32'h0,0, 1,32'h64,1,32'hC000_0064,32'h64,0,32'h68), 1'b0, "btb_cleared");
    apply(V(0,0,J,0,0,32'h0,0,32'h0,32'h0,0, 1,32'h68,0,32'h0,32'h0,0,32'h0), 1'b0, "after_clear");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
